float2fxp_stream: RTL and testbench

FLOAT2FXP_STREAM -- requirements
Module: float2fxp_stream

---
 rtl/float2fxp_stream_if.sv | 25 ++
 rtl/float2fxp_stream.sv | 174 +++++++++++++++++
 tb/tb_float2fxp_stream.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/float2fxp_stream_if.sv
// Stream bundle for float2fxp_stream: float input channel and fixed-point
// result channel, each with its own valid/ready handshake.
interface float2fxp_stream_if #(
  parameter int W = 16
);
  logic         i_valid;
  logic         i_ready;
  logic [31:0]  i_float;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_fxp;
  logic         o_upflow;
  logic         o_downflow;
  logic         o_nan;

  modport slave (
    input  i_valid, i_float, o_ready,
    output i_ready, o_valid, o_fxp, o_upflow, o_downflow, o_nan
  );

  modport master (
    output i_valid, i_float, o_ready,
    input  i_ready, o_valid, o_fxp, o_upflow, o_downflow, o_nan
  );
endinterface

// File: rtl/float2fxp_stream.sv
// IEEE-754 single to signed fixed-point Q(WOI.WOF) converter, 3-stage elastic
// pipeline: unpack/classify, align with guard+sticky, round/negate/saturate.
module float2fxp_stream #(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  float2fxp_stream_if.slave st,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] err_cnt
);
  localparam int W  = WOI + WOF;
  localparam int MW = W + 1;  // one spare bit so the negative limit 2^(W-1) is representable
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [MW:0]  LIMP = {2'b00, MAXV};
  localparam logic [MW:0]  LIMN = {2'b00, MINV};

  // stage valids and load enables; a stage loads when empty or its successor loads
  logic [3:1] vld_q;
  logic [3:1] ld;
  assign ld[3] = ~vld_q[3] | st.o_ready;
  assign ld[2] = ~vld_q[2] | ld[3];
  assign ld[1] = ~vld_q[1] | ld[2];
  assign st.i_ready = ld[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_q <= '0;
    else begin
      if (ld[1]) vld_q[1] <= st.i_valid;
      if (ld[2]) vld_q[2] <= vld_q[1];
      if (ld[3]) vld_q[3] <= vld_q[2];
    end
  end

  // ---------------- S1: unpack and classify
  logic [7:0]         f_exp;
  logic [22:0]        f_man;
  logic signed [11:0] sh_d;
  assign f_exp = st.i_float[30:23];
  assign f_man = st.i_float[22:0];
  // value * 2^WOF = mant * 2^sh
  assign sh_d  = 12'($signed({1'b0, f_exp}) - 150 + WOF);

  logic               s1_sgn_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [23:0]        s1_mant_q;
  logic signed [11:0] s1_sh_q;

  always_ff @(posedge clk) begin
    if (ld[1] && st.i_valid) begin
      s1_sgn_q  <= st.i_float[31];
      s1_nan_q  <= (f_exp == 8'hFF) && (f_man != '0);
      s1_inf_q  <= (f_exp == 8'hFF) && (f_man == '0);
      s1_zero_q <= (f_exp == 8'h00);
      s1_mant_q <= {1'b1, f_man};
      s1_sh_q   <= sh_d;
    end
  end

  // ---------------- S2: align shift, guard and sticky
  logic [MW-1:0]  mag_d;
  logic           big_d, grd_d, stk_d;
  logic [MW+23:0] lwide, rint;
  logic [49:0]    rwide;
  logic [5:0]     rs;

  always_comb begin
    mag_d = '0;
    big_d = 1'b0;
    grd_d = 1'b0;
    stk_d = 1'b0;
    lwide = '0;
    rwide = '0;
    rint  = '0;
    rs    = '0;
    if (s1_zero_q || s1_nan_q || s1_inf_q) begin
      mag_d = '0;
    end else if (!s1_sh_q[11]) begin
      if (int'(s1_sh_q) >= MW) big_d = 1'b1;
      else begin
        lwide = {{MW{1'b0}}, s1_mant_q} << s1_sh_q;
        mag_d = lwide[MW-1:0];
        big_d = |lwide[MW+23:MW];
      end
    end else begin
      // beyond 26 every mantissa bit lands in sticky
      rs    = (s1_sh_q < -12'sd26) ? 6'd26 : 6'(-s1_sh_q);
      rwide = {s1_mant_q, 26'b0} >> rs;
      rint  = {{MW{1'b0}}, rwide[49:26]};
      mag_d = rint[MW-1:0];
      big_d = |rint[MW+23:MW];
      grd_d = rwide[25];
      stk_d = |rwide[24:0];
    end
  end

  logic          s2_sgn_q, s2_nan_q, s2_inf_q, s2_big_q, s2_grd_q, s2_stk_q;
  logic [MW-1:0] s2_mag_q;

  always_ff @(posedge clk) begin
    if (ld[2] && vld_q[1]) begin
      s2_sgn_q <= s1_sgn_q;
      s2_nan_q <= s1_nan_q;
      s2_inf_q <= s1_inf_q;
      s2_big_q <= big_d;
      s2_grd_q <= grd_d;
      s2_stk_q <= stk_d;
      s2_mag_q <= mag_d;
    end
  end

  // ---------------- S3: round magnitude, negate, saturate or wrap
  logic          rnd;
  logic [MW:0]   mag_r;
  logic [W-1:0]  low, fxp_d;
  logic          ovf, up_d, dn_d, nan_d;

  assign rnd   = (ROUND != 0) & s2_grd_q;
  assign mag_r = {1'b0, s2_mag_q} + {{MW{1'b0}}, rnd};
  assign low   = mag_r[W-1:0];
  assign ovf   = s2_big_q | (mag_r > (s2_sgn_q ? LIMN : LIMP));

  always_comb begin
    fxp_d = s2_sgn_q ? -low : low;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    nan_d = 1'b0;
    if (s2_nan_q) begin
      fxp_d = '0;
      nan_d = 1'b1;
    end else if (s2_inf_q) begin
      fxp_d = s2_sgn_q ? MINV : MAXV;
      up_d  = 1'b1;
    end else if (ovf) begin
      up_d = 1'b1;
      if (ROOF != 0) fxp_d = s2_sgn_q ? MINV : MAXV;
    end else begin
      // bits were dropped and nothing survived
      dn_d = (mag_r == '0) && (s2_grd_q || s2_stk_q);
    end
  end

  logic [W-1:0] s3_fxp_q;
  logic         s3_up_q, s3_dn_q, s3_nan_q;

  always_ff @(posedge clk) begin
    if (ld[3] && vld_q[2]) begin
      s3_fxp_q <= fxp_d;
      s3_up_q  <= up_d;
      s3_dn_q  <= dn_d;
      s3_nan_q <= nan_d;
    end
  end

  assign st.o_valid    = vld_q[3];
  assign st.o_fxp      = s3_fxp_q;
  assign st.o_upflow   = s3_up_q;
  assign st.o_downflow = s3_dn_q;
  assign st.o_nan      = s3_nan_q;

  // ---------------- error counter, saturating, clear wins
  logic [CNTW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (vld_q[3] && st.o_ready && (s3_up_q || s3_nan_q) && !(&cnt_q))
      cnt_q <= cnt_q + 1'b1;
  end
  assign err_cnt = cnt_q;
endmodule

// File: tb/tb_float2fxp_stream.sv
// Scoreboard bench for float2fxp_stream in Q10.10: directed vectors pushed as
// expected results on input transfer, checked by an independent output monitor.
module tb_float2fxp_stream;
  localparam int WOI  = 10;
  localparam int WOF  = 10;
  localparam int W    = WOI + WOF;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cnt_clr = 1'b0;
  logic [CNTW-1:0] err_cnt;

  float2fxp_stream_if #(.W(W)) st();

  float2fxp_stream #(.WOI(WOI), .WOF(WOF), .ROOF(1), .ROUND(1), .CNTW(CNTW)) dut (
    .clk(clk), .rstn(rstn), .st(st), .cnt_clr(cnt_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] fxp;
    logic         up;
    logic         dn;
    logic         nan;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [W-1:0] f, input logic u, input logic d, input logic n);
    mk = {f, u, d, n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // output monitor: pops on each output transfer, checks hold-stability under stall
  exp_t mon_cur, mon_held, mon_e;
  logic mon_stall = 1'b0;
  always @(negedge clk) begin
    if (!rstn) mon_stall = 1'b0;
    else begin
      mon_cur = {st.o_fxp, st.o_upflow, st.o_downflow, st.o_nan};
      if (mon_stall) check("hold_stable", {8'd0, st.o_valid, mon_cur}, {8'd0, 1'b1, mon_held});
      if (st.o_valid && st.o_ready) begin
        if (sb.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("out_word", {9'd0, mon_cur}, {9'd0, mon_e});
        end
        mon_stall = 1'b0;
      end else if (st.o_valid) begin
        mon_stall = 1'b1;
        mon_held  = mon_cur;
      end else mon_stall = 1'b0;
    end
  end

  // all main-flow tasks start and end at posedge+1
  task automatic send(input logic [31:0] f, input exp_t e);
    st.i_valid = 1'b1;
    st.i_float = f;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (st.i_ready) begin
        sb.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !st.o_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("drain_timeout", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_f[5];
  exp_t        bp_e[5];
  int          bp_idx;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st.i_valid = 1'b0;
    st.i_float = '0;
    st.o_ready = 1'b1;
    #12;
    check("rst_o_valid", st.o_valid, 0);
    check("rst_i_ready", st.i_ready, 1);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // latency: o_valid in the third cycle after the transfer
    send(32'hC19D957C, mk(20'hFB135, 0, 0, 0));
    st.i_valid = 1'b0;
    @(negedge clk); check("lat_c1", st.o_valid, 0);
    @(negedge clk); check("lat_c2", st.o_valid, 0);
    @(negedge clk); check("lat_c3", st.o_valid, 1);
    @(posedge clk); #1;
    drain();

    // back-to-back: 3 upflow + 1 NaN
    send(32'h407E7564, mk(20'h00FE7, 0, 0, 0));
    send(32'h44696E31, mk(20'h7FFFF, 1, 0, 0));
    send(32'h7F800000, mk(20'h7FFFF, 1, 0, 0));
    send(32'hFF800000, mk(20'h80000, 1, 0, 0));
    send(32'h7FC00000, mk(20'h00000, 0, 0, 1));
    send(32'h30000000, mk(20'h00000, 0, 1, 0));
    send(32'h80000000, mk(20'h00000, 0, 0, 0));
    st.i_valid = 1'b0;
    drain();
    check("err_cnt_4", err_cnt, 4);

    // clear coincides with an upflow output transfer
    send(32'h44000000, mk(20'h7FFFF, 1, 0, 0));
    st.i_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (st.o_valid) break;
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("cnt_clr_prec", err_cnt, 0);

    // boundaries: exact min, rounding, tiny values, huge, round-into-overflow
    send(32'hC4000000, mk(20'h80000, 0, 0, 0));
    send(32'h3F800000, mk(20'h00400, 0, 0, 0));
    send(32'h3A000000, mk(20'h00001, 0, 0, 0));
    send(32'hBA000000, mk(20'hFFFFF, 0, 0, 0));
    send(32'h39800000, mk(20'h00000, 0, 1, 0));
    send(32'h7F000000, mk(20'h7FFFF, 1, 0, 0));
    send(32'hC4800000, mk(20'h80000, 1, 0, 0));
    send(32'h43FFFFFF, mk(20'h7FFFF, 1, 0, 0));
    st.i_valid = 1'b0;
    drain();
    check("err_cnt_3", err_cnt, 3);

    // backpressure: 5 words offered for 6 cycles with o_ready low
    bp_f[0] = 32'h3F800000; bp_e[0] = mk(20'h00400, 0, 0, 0);
    bp_f[1] = 32'h40000000; bp_e[1] = mk(20'h00800, 0, 0, 0);
    bp_f[2] = 32'hBF800000; bp_e[2] = mk(20'hFFC00, 0, 0, 0);
    bp_f[3] = 32'h3E800000; bp_e[3] = mk(20'h00100, 0, 0, 0);
    bp_f[4] = 32'hC07E7564; bp_e[4] = mk(20'hFF019, 0, 0, 0);
    st.o_ready = 1'b0;
    bp_idx = 0;
    for (int c = 0; c < 6; c++) begin
      st.i_valid = 1'b1;
      st.i_float = bp_f[bp_idx];
      @(negedge clk);
      if (st.i_ready) begin
        sb.push_back(bp_e[bp_idx]);
        bp_idx++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", bp_idx, 3);
    @(negedge clk);
    check("bp_i_ready", st.i_ready, 0);
    check("bp_o_valid", st.o_valid, 1);
    @(posedge clk); #1;
    st.o_ready = 1'b1;
    send(bp_f[3], bp_e[3]);
    send(bp_f[4], bp_e[4]);
    st.i_valid = 1'b0;
    drain();

    // reset with 3 words in flight
    st.o_ready = 1'b0;
    send(32'h3F800000, mk(20'h00400, 0, 0, 0));
    send(32'h40000000, mk(20'h00800, 0, 0, 0));
    send(32'h44000000, mk(20'h7FFFF, 1, 0, 0));
    st.i_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_o_valid", st.o_valid, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_i_ready", st.i_ready, 1);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    st.o_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", st.o_valid, 0);
    check("post_rst_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
